// File: rtl/decrypt_iter_pkg.sv
// Shared widths, state encoding and DES datapath helpers (IP, FP, PC1, PC2, round function).
// Bit numbering follows the DES tables: table entry 1 is the MSB of the source word.
package decrypt_iter_pkg;

    localparam int N_K  = 64;
    localparam int N_B  = 64;
    localparam int N_R  = 16;
    localparam int N_CD = 56;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
    };

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int E_TBL [48] = '{
        32, 1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
    };

    localparam int P_TBL [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1,  15, 23, 26, 5,  18, 31, 10,
        2,  8, 24, 14, 32, 27, 3,  9,  19, 13, 30, 6,  22, 11, 4,  25
    };

    // Each S-box is 64 nibbles, row-major (row*16 + col), first entry in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        for (int i = 0; i < 64; i++) perm_ip[63-i] = x[64-IP_TBL[i]];
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) perm_fp[63-i] = x[64-FP_TBL[i]];
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) perm_pc1[55-i] = x[64-PC1_TBL[i]];
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) perm_pc2[47-i] = x[56-PC2_TBL[i]];
    endfunction

    // Feistel function: expand, key mix, S-box substitution, P permutation.
    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] sk);
        logic [47:0] e;
        logic [31:0] s;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TBL[i]];
        e = e ^ sk;
        for (int j = 0; j < 8; j++) begin
            six = e[47-6*j -: 6];
            idx = int'({six[5], six[0], six[4:1]});
            s[31-4*j -: 4] = SBOX[j][255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) des_f[31-i] = s[32-P_TBL[i]];
    endfunction

endpackage

// File: rtl/decrypt_iter_key_schedule_inv.sv
// Decrypt-direction key schedule step: right-rotates both 28-bit CD halves by the
// amount for round i, and derives that round's subkey from the rotated CD via PC2.
module key_schedule_inv
    import decrypt_iter_pkg::*;
(
    input  logic [55:0] x,
    input  logic [3:0]  i,
    output logic [55:0] r,
    output logic [47:0] k
);

    function automatic logic [1:0] rot_amt(input logic [3:0] n);
        case (n)
            4'd0:                rot_amt = 2'd0;
            4'd1, 4'd8, 4'd15:   rot_amt = 2'd1;
            default:             rot_amt = 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] h, input logic [1:0] n);
        case (n)
            2'd1:    rotr28 = {h[0],   h[27:1]};
            2'd2:    rotr28 = {h[1:0], h[27:2]};
            default: rotr28 = h;
        endcase
    endfunction

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        r = {rotr28(x[55:28], rot_amt(i)), rotr28(x[27:0], rot_amt(i))};
        k = perm_pc2(r);
    end

endmodule

// File: rtl/decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock under a four-phase req/ack handshake.
// k and c are sampled only on the IDLE->ROUND edge; m is registered and held until the next completion.
module decrypt_iter
    import decrypt_iter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ack,
    input  logic [63:0] k,
    input  logic [63:0] c,
    output logic [63:0] m
);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] l;
    logic [31:0] r;
    logic [55:0] cd;

    logic [55:0] cd_next;
    logic [47:0] subkey;
    logic [31:0] r_next;

    key_schedule_inv u_ks (
        .x (cd),
        .i (cnt),
        .r (cd_next),
        .k (subkey)
    );

    assign r_next = l ^ des_f(r, subkey);

    // NOTE: all state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ack   <= 1'b0;
            m     <= '0;
            cnt   <= '0;
            l     <= '0;
            r     <= '0;
            cd    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        {l, r} <= perm_ip(c);
                        cd     <= perm_pc1(k);
                        cnt    <= '0;
                        state  <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    l   <= r;
                    r   <= r_next;
                    cd  <= cd_next;
                    cnt <= cnt + 4'd1;
                    // Last round: output halves are swapped before the final permutation.
                    if (cnt == 4'(N_R - 1)) begin
                        m     <= perm_fp({r_next, r});
                        ack   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_iter.sv
// Directed bench for decrypt_iter using published DES known-answer vectors.
module tb_decrypt_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        ack;
    logic [63:0] k;
    logic [63:0] c;
    logic [63:0] m;

    int tests_run = 0;
    int tests_failed = 0;

    decrypt_iter dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .ack (ack),
        .k   (k),
        .c   (c),
        .m   (m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and checks exact latency and the plaintext; leaves req high in DONE.
    task automatic run_op(input string tag, input logic [63:0] key, input logic [63:0] ct,
                          input logic [63:0] pt);
        k   = key;
        c   = ct;
        req = 1'b1;
        repeat (16) tick();
        check({tag, "_ack_before"}, {63'd0, ack}, 64'd0);
        tick();
        check({tag, "_ack"}, {63'd0, ack}, 64'd1);
        check({tag, "_m"}, m, pt);
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        k   = '0;
        c   = '0;
        repeat (2) tick();
        check("reset_ack", {63'd0, ack}, 64'd0);
        check("reset_m", m, 64'd0);
        rst = 1'b0;
        tick();
        check("idle_ack", {63'd0, ack}, 64'd0);

        // Textbook vector, then release the handshake.
        run_op("v1", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
        req = 1'b0;
        tick();
        check("v1_ack_fall", {63'd0, ack}, 64'd0);
        check("v1_m_hold", m, 64'h0123456789ABCDEF);
        tick();

        // All-zero key and plaintext; req held high must not restart.
        run_op("v2", 64'h0, 64'h8CA64DE9C1B123A7, 64'h0);
        for (int i = 0; i < 10; i++) begin
            c = 64'h85E813540F0AB405;
            tick();
            check("v2_hold_ack", {63'd0, ack}, 64'd1);
        end
        check("v2_hold_m", m, 64'h0);
        req = 1'b0;
        tick();
        check("v2_ack_fall", {63'd0, ack}, 64'd0);

        // Back-to-back operations with req low for exactly one cycle between them.
        run_op("v3", 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787);
        req = 1'b0;
        tick();
        run_op("v4", 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF);
        req = 1'b0;
        tick();
        run_op("v5", 64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074);
        req = 1'b0;
        tick();
        run_op("v6", 64'h1111111111111111, 64'hF40379AB9E0EC533, 64'h1111111111111111);
        req = 1'b0;
        tick();

        // Asynchronous reset at round 7 discards the operation and clears m immediately.
        k   = 64'h133457799BBCDFF1;
        c   = 64'h85E813540F0AB405;
        req = 1'b1;
        repeat (8) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ack", {63'd0, ack}, 64'd0);
        check("rst_mid_m", m, 64'h0);
        #1 rst = 1'b0;
        run_op("v1_retry", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
        req = 1'b0;
        tick();

        // Inputs change mid-operation; req drops before completion so ack pulses once.
        k   = 64'hFFFFFFFFFFFFFFFF;
        c   = 64'h7359B2163E4EDC58;
        req = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            k = {$urandom, $urandom};
            c = {$urandom, $urandom};
            tick();
        end
        repeat (4) tick();
        check("chg_ack_before", {63'd0, ack}, 64'd0);
        req = 1'b0;
        tick();
        check("chg_ack", {63'd0, ack}, 64'd1);
        check("chg_m", m, 64'hFFFFFFFFFFFFFFFF);
        tick();
        check("chg_ack_pulse", {63'd0, ack}, 64'd0);
        repeat (20) tick();
        check("chg_no_restart", {63'd0, ack}, 64'd0);
        check("chg_m_hold", m, 64'hFFFFFFFFFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
